pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline-register chain; successor to the fixed IF/ID and ID/EX registers in the risc_v top level.
- Carries a DATA_W payload through STAGES registered slots. Each slot has a valid bit.
- Supports valid/ready backpressure, bubble collapsing, per-stage flush (for branch/jump kill) and occupancy reporting.
- Instantiated between pipeline stages; the control block drives i_flush.

Parameters:
- DATA_W, 32, payload width in bits (PC + instruction, or the full ID/EX bundle).
- STAGES, 4, number of register slots; legal range 1..16.
- CNT_W, $clog2(STAGES+1), occupancy counter width (derived, not overridden).

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  asynchronous reset, active-low (asserted when 0)
- i_valid  in  1  upstream offers i_data
- i_data  in  DATA_W  upstream payload
- o_ready  out  1  chain accepts i_data this cycle
- o_valid  out  1  slot STAGES-1 holds a valid item
- o_data  out  DATA_W  payload of slot STAGES-1
- i_ready  in  1  downstream accepts o_data this cycle
- i_flush  in  STAGES  per-slot kill; bit k clears slot k
- o_count  out  CNT_W  number of valid slots
- o_empty  out  1  o_count == 0
- o_full  out  1  o_count == STAGES

Behaviour:
- Slot k holds valid_k and data_k. Slot 0 is the input side; slot STAGES-1 drives o_valid and o_data.
- Reset (i_rst=0, async): all valid_k=0 and all data_k=0. Outputs follow: o_valid=0, o_data=0, o_count=0, o_empty=1, o_full=0. o_ready=1 once reset is released.
- Reset mid-stream discards all items immediately. No partial state survives.
- Slot ready: rdy_STAGES = i_ready; rdy_k = !valid_k | rdy_{k+1}. This is a combinational chain; no registered skid.
- o_ready = rdy_0. It is independent of i_flush.
- Upstream transfer: i_valid & o_ready. Downstream transfer: o_valid & i_ready.
- At each edge, slot k loads from slot k-1 (slot 0 loads from the input) when rdy_k = 1:
  - data_k <= data_{k-1}
  - valid_k <= valid_{k-1}, or i_valid for slot 0
- When rdy_k = 0, slot k holds its value.
- Bubble collapse: an invalid slot always loads, so gaps close while downstream is stalled.
- Flush priority: i_flush[k]=1 forces valid_k <= 0 at the edge, overriding any load. The item arriving into slot k that cycle is dropped.
- Flush does not alter rdy or the handshakes. An upstream transfer into a flushed slot 0 still completes from the upstream view and is discarded.
- Flushing slot STAGES-1 while o_valid & i_ready still counts as a completed downstream transfer that cycle. Downstream samples before the edge.
- Data of invalid slots is don't-care for output; only o_data qualified by o_valid is meaningful.
- Latency, empty chain, i_ready=1: item accepted at edge t is visible at o_valid/o_data after edge t+STAGES-1, i.e. STAGES cycles from i_valid sampling.
- Throughput: 1 item/cycle with i_ready=1.
- Full with i_ready=0: o_ready=0, all slots hold.
- Full with i_ready=1: simultaneous accept and emit; o_count unchanged.
- o_count is registered and updated each edge as the popcount of the next valid vector. o_empty and o_full are derived from the registered count.
- STAGES=1 degenerates to a single registered slot with rdy_0 = !valid_0 | i_ready.
- Payload is never modified; no reordering; items exit in acceptance order.

Decomposition:
- Shared package pipe_pkg: STAGE_MAX=16, the CNT_W computation function, and the default widths WORD_SIZE=32 and PC_SIZE=32.
- One natural sub-module, pipe_slot: a single valid+data register with load, flush and async active-low reset.
- pipe_stage_chain generates STAGES instances of pipe_slot, plus the rdy chain and the counter.

Test Plan (STAGES=4, DATA_W=32):
- Reset: hold i_rst=0 with i_valid=1 -> o_valid=0, o_count=0, o_empty=1, o_ready=1. Release, then push 0xA5A5_0001 -> o_valid=1 with o_data=0xA5A5_0001 after exactly 4 edges.
- Streaming: push 0x1..0x8 back-to-back with i_ready=1 -> outputs 0x1..0x8 in order on consecutive cycles; o_count plateaus at 4.
- Backpressure: i_ready=0, push 6 items -> o_ready drops after 4 accepts, o_full=1. Raise i_ready -> 6 items drain in order with no duplicates.
- Bubble collapse: push 0x10, idle 2 cycles, push 0x11, with i_ready=0 -> both packed into slots 3 and 2 after the gap closes; o_count=2.
- Flush: chain full with 0x20..0x23 and i_flush=4'b0011 for one cycle -> o_count=2. Only 0x20 and 0x21 emerge; 0x22 and 0x23 never appear.
- Async reset mid-stream: assert i_rst=0 between edges with 3 items in flight -> o_valid=0 and o_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared limits, default widths and counter-width helper for the pipeline chain
package pipe_pkg;
  localparam int STAGE_MAX = 16;
  localparam int WORD_SIZE = 32;
  localparam int PC_SIZE = 32;
  function automatic int cnt_w(input int stages);
    return $clog2(stages + 1);
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data register with load, flush priority and async active-low reset
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  always_comb begin
    valid_d = i_flush ? 1'b0 : i_load ? i_valid : valid_q;
    data_d = i_load ? i_data : data_q;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
  assign o_valid = valid_q;
  assign o_data = data_q;
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with bubble collapse, per-slot flush and occupancy count
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE,
  parameter int STAGES = 4,
  localparam int CNT_W = cnt_w(STAGES)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  input  logic [STAGES-1:0] i_flush,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);
  logic              v_chain [STAGES+1];
  logic [DATA_W-1:0] d_chain [STAGES+1];
  logic [STAGES:0]   rdy;
  logic [CNT_W-1:0]  count_d, count_q;
  assign v_chain[0] = i_valid;
  assign d_chain[0] = i_data;
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    pipe_slot #(.DATA_W(DATA_W)) u_slot (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (rdy[k]),
      .i_flush(i_flush[k]),
      .i_valid(v_chain[k]),
      .i_data (d_chain[k]),
      .o_valid(v_chain[k+1]),
      .o_data (d_chain[k+1])
    );
  end
  always_comb begin
    rdy = '0;
    rdy[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !v_chain[k+1] | rdy[k+1];
  end
  always_comb begin
    count_d = '0;
    for (int k = 0; k < STAGES; k++)
      count_d = count_d + CNT_W'(!i_flush[k] & (rdy[k] ? v_chain[k] : v_chain[k+1]));
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) count_q <= '0;
    else count_q <= count_d;
  end
  assign o_ready = rdy[0];
  assign o_valid = v_chain[STAGES];
  assign o_data = d_chain[STAGES];
  assign o_count = count_q;
  assign o_empty = count_q == '0;
  assign o_full = count_q == CNT_W'(STAGES);
endmodule
